// File: rtl/acc_mc_pkg.sv
// acc_mc_pkg: shared definitions for the multicycle accumulator core.
//   - opcode_e : 4-bit instruction opcodes (B..E are unassigned and trap)
//   - state_e  : controller states
//   - op_field / addr_field : split an instruction word {opcode, addr}
//     of width data_w into its two fields.
package acc_mc_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_NOT = 4'h7,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_JN  = 4'hA,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_MEMRD,
        ST_MEMWR,
        ST_HALT
    } state_e;

    // Opcode lives in the top four bits of the instruction word.
    function automatic logic [3:0] op_field(input logic [63:0] word, input int data_w);
        return 4'(word >> (data_w - 4));
    endfunction

    // Address is everything below the opcode.
    function automatic logic [63:0] addr_field(input logic [63:0] word, input int data_w);
        return word & ((64'd1 << (data_w - 4)) - 64'd1);
    endfunction

endpackage

// File: rtl/acc_mc_alu.sv
// acc_mc_alu: combinational accumulator ALU.
//   op     : instruction opcode
//   a      : current accumulator
//   b      : memory operand
//   result : new accumulator value (modulo 2^DATA_W, no flags)
// Opcodes that do not change the accumulator pass a through.
module acc_mc_alu
    import acc_mc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = a;
        case (op)
            OP_LDA:  result = b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/acc_mc_core.sv
// acc_mc_core: multicycle accumulator processor behind a single memory port.
//   clk, rst                 : clock, asynchronous active-low reset
//   mem_req/we/addr/wdata    : memory request, decoded from state/pc/ir/acc
//   mem_rdata, mem_ready     : read data and completion (used only while mem_req)
//   acc, pc                  : architectural state (debug)
//   halted, illegal          : stopped by HLT / by an unassigned opcode
//   retired                  : retired-instruction counter (wraps)
module acc_mc_core
    import acc_mc_pkg::*;
#(
    parameter int  DATA_W   = 16,
    parameter int  RESET_PC = 0,
    parameter int  CNT_W    = 16,
    localparam int ADDR_W   = DATA_W - 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    state_e            state;
    logic [DATA_W-1:0] ir;
    logic [3:0]        ir_op;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] alu_y;
    logic              retire;

    assign ir_op   = op_field(64'(ir), DATA_W);
    assign ir_addr = ADDR_W'(addr_field(64'(ir), DATA_W));

    acc_mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (ir_op),
        .a      (acc),
        .b      (mem_rdata),
        .result (alu_y)
    );

    // Request is a pure function of state, so it falls with reset and
    // holds steady for as long as mem_ready stays low.
    assign mem_wdata = acc;

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            ST_MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = ir_addr;
            end
            ST_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ir_addr;
            end
            default: ;
        endcase
    end

    // Single-cycle instructions retire in DECODE; memory instructions
    // retire on their operand handshake. Illegal opcodes never retire.
    always_comb begin
        retire = 1'b0;
        case (state)
            ST_DECODE:          retire = ir_op inside {OP_NOP, OP_NOT, OP_JMP, OP_JZ, OP_JN, OP_HLT};
            ST_MEMRD, ST_MEMWR: retire = mem_ready;
            default:            retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_BOOT;
            pc      <= ADDR_W'(RESET_PC);
            ir      <= '0;
            acc     <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (retire)
                retired <= retired + CNT_W'(1);
            case (state)
                ST_BOOT: state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state <= ST_FETCH;
                    case (ir_op)
                        OP_NOP: ;
                        OP_NOT: acc <= alu_y;
                        OP_JMP: pc <= ir_addr;
                        OP_JZ:  if (acc == '0) pc <= ir_addr;
                        OP_JN:  if (acc[DATA_W-1]) pc <= ir_addr;
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state <= ST_MEMRD;
                        OP_STA: state <= ST_MEMWR;
                        OP_HLT: begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                        default: begin
                            state   <= ST_HALT;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                ST_MEMRD: begin
                    if (mem_ready) begin
                        acc   <= alu_y;
                        state <= ST_FETCH;
                    end
                end
                ST_MEMWR: begin
                    if (mem_ready)
                        state <= ST_FETCH;
                end
                ST_HALT: ;
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_mc_core.sv
module tb_acc_mc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit core
    logic        rst16, req16, we16, rdy16, halted16, illegal16;
    logic [11:0] addr16, pc16;
    logic [15:0] wdata16, rdata16, acc16, ret16;
    // 8-bit core, RESET_PC = 4
    logic        rst8, req8, we8, rdy8, halted8, illegal8;
    logic [3:0]  addr8, pc8;
    logic [7:0]  wdata8, rdata8, acc8, ret8;

    acc_mc_core #(.DATA_W(16), .RESET_PC(0), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
        .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(rdy16), .acc(acc16),
        .pc(pc16), .halted(halted16), .illegal(illegal16), .retired(ret16));

    acc_mc_core #(.DATA_W(8), .RESET_PC(4), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst8), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ready(rdy8), .acc(acc8),
        .pc(pc8), .halted(halted8), .illegal(illegal8), .retired(ret8));

    logic [15:0] mem16 [0:4095];
    logic [7:0]  mem8  [0:15];
    int          cnt16, cur_w16, wait16, stab_err;
    bit          rand16;
    logic        p_req, p_rdy, p_we;
    logic [11:0] p_addr;
    logic [15:0] p_wdata;
    int          n_checks, n_fail;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] a;
        logic [15:0] pre, opnd, exp_acc;
        logic [11:0] exp_pc;
        logic [15:0] exp_mem;
    } vec_t;
    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: memory models respond at the negedge, commit at the posedge.
    task automatic cyc();
        @(negedge clk);
        if (rst16) begin
            if (p_req && !p_rdy && req16 &&
                (addr16 !== p_addr || we16 !== p_we || wdata16 !== p_wdata)) stab_err++;
            // a request right after completion must be a fresh fetch
            if (p_req && p_rdy && req16 && (we16 || addr16 !== pc16)) stab_err++;
        end
        rdy16   = req16 && (cnt16 >= cur_w16);
        rdata16 = mem16[addr16];
        rdy8    = req8;
        rdata8  = mem8[addr8];
        p_req = req16; p_rdy = rdy16; p_we = we16; p_addr = addr16; p_wdata = wdata16;
        @(posedge clk);
        if (rst16) begin
            if (p_rdy) begin
                if (p_we) mem16[p_addr] = p_wdata;
                cnt16   = 0;
                cur_w16 = rand16 ? int'($urandom_range(0, 3)) : wait16;
            end else if (p_req) begin
                cnt16++;
            end
        end
        #1;
    endtask

    task automatic reset16();
        rst16   = 1'b0;
        cnt16   = 0;
        cur_w16 = rand16 ? int'($urandom_range(0, 3)) : wait16;
        p_req   = 1'b0;
        p_rdy   = 1'b0;
        repeat (2) cyc();
        rst16 = 1'b1;
    endtask

    task automatic run16(input int budget, output int ncyc);
        ncyc = 0;
        while (!halted16 && ncyc < budget) begin
            cyc();
            ncyc++;
        end
        check("halt_reached", 32'(halted16), 32'd1);
    endtask

    task automatic clear16();
        for (int i = 0; i < 4096; i++) mem16[i] = '0;
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] a);
        return {op, a};
    endfunction

    int          n, k, nins, cyc_exp, nbad;
    logic [3:0]  op;
    logic [15:0] racc;
    logic [15:0] rm [8];
    bit          saw_wrap, wrap_pending;

    initial begin
        rst16 = 1'b0; rst8 = 1'b0; wait16 = 0; rand16 = 1'b0; cnt16 = 0; cur_w16 = 0;
        rdy16 = 1'b0; rdata16 = '0; rdy8 = 1'b0; rdata8 = '0; stab_err = 0;
        p_req = 1'b0; p_rdy = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        n_checks = 0; n_fail = 0;

        // ---- reset state, boot cycle, zero-wait reference program ----
        clear16();
        mem16[0] = ins(4'h1, 12'h010); mem16[1] = ins(4'h3, 12'h011);
        mem16[2] = ins(4'h2, 12'h012); mem16[3] = 16'hF000;
        mem16[16'h10] = 16'd5; mem16[16'h11] = 16'd7;
        repeat (2) cyc();
        check("rst_req", 32'(req16), 0);    check("rst_we", 32'(we16), 0);
        check("rst_addr", 32'(addr16), 0);  check("rst_wdata", 32'(wdata16), 0);
        check("rst_acc", 32'(acc16), 0);    check("rst_pc", 32'(pc16), 0);
        check("rst_ret", 32'(ret16), 0);    check("rst_halted", 32'(halted16), 0);
        check("rst_illegal", 32'(illegal16), 0);
        check("rst_pc8", 32'(pc8), 32'h4);
        rst16 = 1'b1;
        check("boot_no_req", 32'(req16), 0);
        cyc();
        check("first_fetch_req", 32'(req16), 1);
        check("first_fetch_addr", 32'(addr16), 0);
        run16(100, n);
        check("prog0_cycles", 32'(n), 32'd11);
        check("prog0_mem12", 32'(mem16[16'h12]), 32'd12);
        check("prog0_acc", 32'(acc16), 32'd12);
        check("prog0_ret", 32'(ret16), 32'd4);
        check("prog0_pc", 32'(pc16), 32'd4);
        check("prog0_illegal", 32'(illegal16), 0);

        // ---- same program, 3 wait states on every access ----
        mem16[16'h12] = '0;
        wait16 = 3; stab_err = 0;
        reset16();
        run16(200, n);
        check("prog3w_cycles", 32'(n - 1), 32'd32);
        check("prog3w_mem12", 32'(mem16[16'h12]), 32'd12);
        check("prog3w_ret", 32'(ret16), 32'd4);
        check("prog3w_halted", 32'(halted16), 1);
        check("prog3w_stable", 32'(stab_err), 0);

        // ---- table-driven single-instruction vectors ----
        vt[0]  = '{4'h1, 12'h03F, 16'h1234, 16'h00AB, 16'h00AB, 12'h003, 16'h00AB};
        vt[1]  = '{4'h3, 12'h03F, 16'hFFFF, 16'h0002, 16'h0001, 12'h003, 16'h0002};
        vt[2]  = '{4'h4, 12'h03F, 16'h0003, 16'h0005, 16'hFFFE, 12'h003, 16'h0005};
        vt[3]  = '{4'h5, 12'h03F, 16'hF0F0, 16'h3C3C, 16'h3030, 12'h003, 16'h3C3C};
        vt[4]  = '{4'h6, 12'h03F, 16'hF0F0, 16'h0F01, 16'hFFF1, 12'h003, 16'h0F01};
        vt[5]  = '{4'h7, 12'h000, 16'h00FF, 16'h0000, 16'hFF00, 12'h003, 16'h0000};
        vt[6]  = '{4'h0, 12'h000, 16'h5555, 16'h0000, 16'h5555, 12'h003, 16'h0000};
        vt[7]  = '{4'h9, 12'h020, 16'h0000, 16'h0000, 16'h0000, 12'h021, 16'h0000};
        vt[8]  = '{4'h9, 12'h020, 16'h0001, 16'h0000, 16'h0001, 12'h003, 16'h0000};
        vt[9]  = '{4'hA, 12'h030, 16'h8000, 16'h0000, 16'h8000, 12'h031, 16'h0000};
        vt[10] = '{4'hA, 12'h030, 16'h7FFF, 16'h0000, 16'h7FFF, 12'h003, 16'h0000};
        vt[11] = '{4'h8, 12'h025, 16'h0007, 16'h0000, 16'h0007, 12'h026, 16'h0000};
        vt[12] = '{4'h2, 12'h03F, 16'hBEEF, 16'h1111, 16'hBEEF, 12'h003, 16'hBEEF};
        rand16 = 1'b1;
        for (int i = 0; i < 13; i++) begin
            clear16();
            mem16[0] = ins(4'h1, 12'h03E);
            mem16[1] = ins(vt[i].op, vt[i].a);
            mem16[2] = 16'hF000; mem16[16'h20] = 16'hF000;
            mem16[16'h25] = 16'hF000; mem16[16'h30] = 16'hF000;
            mem16[16'h3E] = vt[i].pre; mem16[16'h3F] = vt[i].opnd;
            reset16();
            run16(100, n);
            check($sformatf("vec%0d_acc", i), 32'(acc16), 32'(vt[i].exp_acc));
            check($sformatf("vec%0d_pc", i), 32'(pc16), 32'(vt[i].exp_pc));
            check($sformatf("vec%0d_ret", i), 32'(ret16), 32'd3);
            check($sformatf("vec%0d_mem", i), 32'(mem16[16'h3F]), 32'(vt[i].exp_mem));
        end
        rand16 = 1'b0;

        // ---- illegal opcode trap ----
        wait16 = 0;
        clear16();
        mem16[0] = 16'hC000;
        reset16();
        run16(50, n);
        check("ill_illegal", 32'(illegal16), 1);
        check("ill_halted", 32'(halted16), 1);
        check("ill_ret", 32'(ret16), 0);
        check("ill_pc", 32'(pc16), 1);
        k = 0;
        repeat (20) begin
            cyc();
            if (req16) k++;
        end
        check("ill_no_req", 32'(k), 0);

        // ---- reset in the 2nd wait cycle of a store ----
        wait16 = 3;
        clear16();
        mem16[0] = ins(4'h1, 12'h03E); mem16[1] = ins(4'h2, 12'h012); mem16[2] = 16'hF000;
        mem16[16'h3E] = 16'hABCD;
        reset16();
        k = 0;
        while (!(req16 && we16) && k < 100) begin cyc(); k++; end
        check("sta_req_seen", 32'(req16 && we16), 1);
        cyc();
        rst16 = 1'b0;
        #1;
        check("mid_rst_req", 32'(req16), 0);      check("mid_rst_we", 32'(we16), 0);
        check("mid_rst_addr", 32'(addr16), 0);    check("mid_rst_wdata", 32'(wdata16), 0);
        check("mid_rst_acc", 32'(acc16), 0);      check("mid_rst_pc", 32'(pc16), 0);
        check("mid_rst_ret", 32'(ret16), 0);      check("mid_rst_halted", 32'(halted16), 0);
        check("mid_rst_illegal", 32'(illegal16), 0);
        check("mid_rst_no_write", 32'(mem16[16'h12]), 0);
        cnt16 = 0; cur_w16 = wait16; p_req = 1'b0; p_rdy = 1'b0;
        cyc();
        rst16 = 1'b1;
        check("mid_rst_boot", 32'(req16), 0);
        cyc();
        check("mid_rst_refetch_req", 32'(req16), 1);
        check("mid_rst_refetch_addr", 32'(addr16), 0);
        run16(200, n);
        check("mid_rst_rerun_mem", 32'(mem16[16'h12]), 32'hABCD);
        check("mid_rst_rerun_ret", 32'(ret16), 3);

        // ---- randomized straight-line programs vs ISA-level model ----
        stab_err = 0;
        for (int it = 0; it < 10; it++) begin
            clear16();
            rand16 = (it % 2) == 1;
            wait16 = 0;
            nins = int'($urandom_range(4, 20));
            for (int j = 0; j < 8; j++) begin
                rm[j] = 16'($urandom);
                mem16[64 + j] = rm[j];
            end
            racc = '0;
            cyc_exp = 2;  // closing HLT
            for (int j = 0; j < nins; j++) begin
                op = 4'($urandom_range(0, 7));
                k  = int'($urandom_range(0, 7));
                mem16[j] = {op, 12'(64 + k)};
                case (op)
                    4'h0: cyc_exp += 2;
                    4'h7: begin racc = ~racc; cyc_exp += 2; end
                    4'h1: begin racc = rm[k]; cyc_exp += 3; end
                    4'h2: begin rm[k] = racc; cyc_exp += 3; end
                    4'h3: begin racc = racc + rm[k]; cyc_exp += 3; end
                    4'h4: begin racc = racc - rm[k]; cyc_exp += 3; end
                    4'h5: begin racc = racc & rm[k]; cyc_exp += 3; end
                    default: begin racc = racc | rm[k]; cyc_exp += 3; end
                endcase
            end
            mem16[nins] = 16'hF000;
            reset16();
            run16(500, n);
            nbad = 0;
            for (int j = 0; j < 8; j++) if (mem16[64 + j] !== rm[j]) nbad++;
            check($sformatf("rnd%0d_acc", it), 32'(acc16), 32'(racc));
            check($sformatf("rnd%0d_pc", it), 32'(pc16), 32'(nins + 1));
            check($sformatf("rnd%0d_ret", it), 32'(ret16), 32'(nins + 1));
            check($sformatf("rnd%0d_mem", it), 32'(nbad), 0);
            if (!rand16) check($sformatf("rnd%0d_cycles", it), 32'(n - 1), 32'(cyc_exp));
        end
        check("rnd_stable", 32'(stab_err), 0);

        // ---- 8-bit core: add wrap and pc wrap, RESET_PC = 4 ----
        for (int i = 0; i < 16; i++) mem8[i] = '0;
        mem8[4] = 8'h1A; mem8[5] = 8'h3B; mem8[6] = 8'h8F;
        mem8[15] = 8'h00; mem8[0] = 8'hF0;
        mem8[10] = 8'hFF; mem8[11] = 8'h01;
        rst8 = 1'b1;
        k = 0; saw_wrap = 1'b0;
        while (!halted8 && k < 100) begin
            wrap_pending = req8 && (addr8 == 4'hF) && (pc8 == 4'hF);
            cyc();
            k++;
            if (wrap_pending) begin
                check("w8_pc_wrap", 32'(pc8), 0);
                saw_wrap = 1'b1;
            end
        end
        check("w8_halted", 32'(halted8), 1);
        check("w8_saw_wrap", 32'(saw_wrap), 1);
        check("w8_acc", 32'(acc8), 0);
        check("w8_pc", 32'(pc8), 1);
        check("w8_ret", 32'(ret8), 5);
        check("w8_illegal", 32'(illegal8), 0);
        check("w8_we", 32'(we8), 0);
        check("w8_wdata", 32'(wdata8), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
